// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the serial one's/two's complementer.
package serial_comp_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StOnes     = 2'd1,
    StTwosPass = 2'd2,
    StTwosInv  = 2'd3
  } state_e;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

  // Two's complement passes bits up to and including the first 1, then inverts.
  function automatic state_e start_state(logic mode, logic first_bit);
    if (mode == MODE_ONES) begin
      return StOnes;
    end
    return first_bit ? StTwosInv : StTwosPass;
  endfunction

endpackage

// File: rtl/serial_complementer_if.sv
// Serial bit stream in, complemented bit stream out, plus framing error pulse.
interface serial_complementer_if;

  logic in_valid;
  logic in_bit;
  logic in_sof;
  logic mode;
  logic out_valid;
  logic out_bit;
  logic out_sof;
  logic out_eow;
  logic err_frame;

  modport master (
    output in_valid, in_bit, in_sof, mode,
    input  out_valid, out_bit, out_sof, out_eow, err_frame
  );

  modport slave (
    input  in_valid, in_bit, in_sof, mode,
    output out_valid, out_bit, out_sof, out_eow, err_frame
  );

endinterface

// File: rtl/serial_comp_ctr.sv
// Word bit counter: clear+inc loads 1 (new word), clear alone returns to 0.
module serial_comp_ctr #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = $clog2(WORD_W)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clear,
  output logic last
);

  localparam logic [CNT_W-1:0] LastVal = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LastVal);

endmodule

// File: rtl/serial_complementer.sv
// Bit-serial one's/two's complementer, LSB first, registered outputs with one cycle latency.
module serial_complementer
  import serial_comp_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = $clog2(WORD_W)
) (
  input logic                  clk,
  input logic                  rst,
  serial_complementer_if.slave bus
);

  state_e state_q, state_d;
  logic   mode_q;

  logic accept, mid, start, eow, emit, frame_err, bit_d;
  logic ctr_inc, ctr_clear, cnt_last;

  logic out_valid_q, out_bit_q, out_sof_q, out_eow_q, err_frame_q;

  serial_comp_ctr #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (ctr_inc),
    .clear(ctr_clear),
    .last (cnt_last)
  );

  always_comb begin
    accept    = bus.in_valid;
    mid       = (state_q != StIdle);
    start     = accept & bus.in_sof;
    eow       = accept & ~bus.in_sof & mid & cnt_last;
    emit      = accept & (bus.in_sof | mid);
    // sof while mid-word, or a bare bit while idle
    frame_err = accept & (bus.in_sof == mid);
    ctr_inc   = emit & ~eow;
    ctr_clear = start | eow;

    state_d = state_q;
    bit_d   = bus.in_bit;
    if (start) begin
      state_d = start_state(bus.mode, bus.in_bit);
      bit_d   = (bus.mode == MODE_ONES) ? ~bus.in_bit : bus.in_bit;
    end else if (accept && mid) begin
      unique case (state_q)
        StOnes:     bit_d = ~bus.in_bit;
        StTwosPass: bit_d = bus.in_bit;
        StTwosInv:  bit_d = ~bus.in_bit;
        default:    bit_d = bus.in_bit;
      endcase
      if (eow) begin
        state_d = StIdle;
      end else if (mode_q == MODE_TWOS && state_q == StTwosPass && bus.in_bit) begin
        state_d = StTwosInv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= MODE_ONES;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eow_q   <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mode_q <= bus.mode;
      end
      out_valid_q <= emit;
      out_bit_q   <= emit & bit_d;
      out_sof_q   <= start;
      out_eow_q   <= eow;
      err_frame_q <= frame_err;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eow   = out_eow_q;
  assign bus.err_frame = err_frame_q;

endmodule

// File: tb/tb_serial_complementer.sv
// Bench for serial_complementer: word-level arithmetic model, per-cycle compare, directed + random.
module tb_serial_complementer;

  localparam int unsigned W = 8;
  localparam logic [63:0] Mask = (W >= 64) ? '1 : ((64'd1 << W) - 64'd1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_complementer_if bus();

  serial_complementer #(.WORD_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  // Model: tracks the word being received and derives each output bit from the arithmetic
  // negation / inversion of the bits seen so far.
  logic        e_valid = 1'b0, e_bit = 1'b0, e_sof = 1'b0, e_eow = 1'b0, e_err = 1'b0;
  logic [63:0] model_words[$];
  logic [63:0] dut_words[$];

  initial begin
    bit          m_active;
    bit          m_mode;
    int          m_idx;
    logic [63:0] m_val;
    logic [63:0] negv;
    m_active = 0; m_mode = 0; m_idx = 0; m_val = '0;
    forever begin
      @(posedge clk or negedge rst);
      {e_valid, e_bit, e_sof, e_eow, e_err} = '0;
      if (!rst) begin
        m_active = 0; m_mode = 0; m_idx = 0; m_val = '0;
      end else if (bus.in_valid) begin
        if (bus.in_sof) begin
          e_err    = m_active;
          m_active = 1; m_mode = bus.mode; m_idx = 0; m_val = '0;
        end else if (!m_active) begin
          e_err = 1'b1;
        end
        if (m_active) begin
          m_val[m_idx] = bus.in_bit;
          negv    = (~m_val + 64'd1) & Mask;
          e_valid = 1'b1;
          e_sof   = (m_idx == 0);
          e_bit   = m_mode ? negv[m_idx] : ~bus.in_bit;
          e_eow   = (m_idx == int'(W) - 1);
          if (e_eow) begin
            model_words.push_back(m_mode ? negv : (~m_val & Mask));
            m_active = 0;
          end
          m_idx++;
        end
      end
    end
  end

  // Per-cycle compare and reassembly of DUT output words.
  initial begin
    logic [63:0] asm_word;
    int          aidx;
    asm_word = '0; aidx = 0;
    forever begin
      @(negedge clk);
      check("cycle outputs",
            64'({bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.err_frame}),
            64'({e_valid, e_bit, e_sof, e_eow, e_err}));
      if (bus.err_frame === 1'b1) err_cnt++;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_sof === 1'b1) begin
          asm_word = '0; aidx = 0;
        end
        if (aidx < 64) asm_word[aidx] = bus.out_bit;
        aidx++;
        if (bus.out_eow === 1'b1) dut_words.push_back(asm_word);
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic s, input logic m);
    @(negedge clk);
    bus.in_valid = v; bus.in_bit = b; bus.in_sof = s; bus.mode = m;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [63:0] val, input int lo, input int hi, input logic m);
    for (int i = lo; i <= hi; i++) drive(1'b1, val[i], (i == 0), m);
  endtask

  task automatic check_word(input string name, input logic [63:0] want);
    logic [63:0] g;
    g = 'x;
    if (dut_words.size() > 0) g = dut_words.pop_front();
    check({name, " dut word"}, g, want);
    g = 'x;
    if (model_words.size() > 0) g = model_words.pop_front();
    check({name, " model word"}, g, want);
  endtask

  initial begin
    int e0;
    int pos;
    logic v, s;
    logic [63:0] a, b;
    bus.in_valid = 0; bus.in_bit = 0; bus.in_sof = 0; bus.mode = 0;

    repeat (3) @(negedge clk);
    check("reset outputs", 64'({bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow,
                                bus.err_frame}), 64'd0);
    rst = 1'b1;
    idle(2);

    send_bits(64'h5A, 0, int'(W) - 1, 1'b0);
    idle(2);
    check_word("ones 5A", 64'hA5);

    // back-to-back words, no bubble between eow and next sof
    send_bits(64'h28, 0, int'(W) - 1, 1'b1);
    send_bits(64'h00, 0, int'(W) - 1, 1'b1);
    send_bits(64'h80, 0, int'(W) - 1, 1'b1);
    idle(2);
    check_word("twos 28", 64'hD8);
    check_word("twos 00", 64'h00);
    check_word("twos 80", 64'h80);

    // stall after bit 3 with mode and junk toggling on the idle inputs
    send_bits(64'h01, 0, 3, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(64'h01, 4, int'(W) - 1, 1'b0);
    idle(2);
    check_word("stall twos 01", 64'hFF);

    e0 = err_cnt;
    send_bits(64'hF0, 0, 3, 1'b0);
    send_bits(64'h03, 0, int'(W) - 1, 1'b1);
    idle(2);
    check("abort err pulses", 64'(err_cnt - e0), 64'd1);
    check_word("abort twos 03", 64'hFD);
    check("abort extra words", 64'(dut_words.size()), 64'd0);

    e0 = err_cnt;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("bare bits err pulses", 64'(err_cnt - e0), 64'd2);
    check("bare bits words", 64'(dut_words.size()), 64'd0);

    // asynchronous reset mid-word, between clock edges
    send_bits(64'hC3, 0, 4, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 check("async reset outputs", 64'({bus.out_valid, bus.out_bit, bus.out_sof,
                                         bus.out_eow, bus.err_frame}), 64'd0);
    idle(3);
    rst = 1'b1;
    send_bits(64'h00, 0, int'(W) - 1, 1'b0);
    idle(2);
    check_word("post reset ones 00", 64'hFF);
    check("post reset extra words", 64'(dut_words.size()), 64'd0);

    // random traffic: mostly well-framed, occasional stalls, aborts and bare bits
    pos = 0;
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 9) != 0);
      if (!v) begin
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        s = (pos == 0) ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 3);
        drive(1'b1, 1'($urandom), s, 1'($urandom));
        if (s) pos = 1;
        else if (pos != 0) pos = (pos == int'(W) - 1) ? 0 : pos + 1;
      end
    end
    idle(3);
    check("random word count", 64'(dut_words.size()), 64'(model_words.size()));
    while (dut_words.size() > 0 && model_words.size() > 0) begin
      a = dut_words.pop_front();
      b = model_words.pop_front();
      check("random word", a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_complementer.md
SERIAL_COMPLEMENTER -- requirements
Module: serial_complementer

Interface
REQ-001 Parameter WORD_W, default 8, bits per serial word; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WORD_W), width of the internal bit counter; derived, not overridden.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_bit/in_sof/mode are valid this cycle; when low, the cycle is a stall.
REQ-006 in_bit  input  1  serial data bit, LSB first.
REQ-007 in_sof  input  1  marks the first (LSB) bit of a word; qualified by in_valid.
REQ-008 mode  input  1  0 = one's complement, 1 = two's complement; sampled only on an accepted sof bit.
REQ-009 out_valid  output  1  out_bit is valid.
REQ-010 out_bit  output  1  complemented serial bit, LSB first.
REQ-011 out_sof  output  1  first output bit of a word.
REQ-012 out_eow  output  1  last (WORD_W-th) output bit of a word.
REQ-013 err_frame  output  1  one-cycle pulse on a framing violation.

Function
REQ-014 The block SHALL use four states: IDLE, ONES, TWOS_PASS and TWOS_INV.
REQ-015 An accepted bit is one with in_valid=1; on in_valid=0, state and counter SHALL hold, and out_valid SHALL be 0 on the next cycle.
REQ-016 In IDLE, an accepted bit with in_sof=1 SHALL start a word:
  - counter set to 1;
  - mode latched;
  - the bit processed under the rules for the new mode.
REQ-017 Per-bit rules:
  - ONES: out=~in.
  - TWOS_PASS: out=in; if in=1, go to TWOS_INV.
  - TWOS_INV: out=~in.
  - A word start in mode 1 SHALL enter TWOS_PASS, or TWOS_INV if the sof bit is 1.
REQ-018 Output SHALL be registered with latency exactly 1 cycle:
  - out_valid, out_bit, out_sof and out_eow reflect the bit accepted on the previous edge;
  - all four are 0 in cycles with no accepted bit.
REQ-019 The counter SHALL increment on each accepted bit. The accepted bit with counter = WORD_W-1 SHALL produce out_eow=1, return the state to IDLE and clear the counter.
REQ-020 An accepted bit with in_sof=0 while in IDLE SHALL be dropped (no out_valid) and SHALL pulse err_frame.
REQ-021 An accepted bit with in_sof=1 while mid-word SHALL:
  - abort the current word, with no out_eow issued for it;
  - pulse err_frame;
  - start a new word with that bit per REQ-016.
REQ-022 A word's eow bit and the next word's sof bit MAY arrive on consecutive cycles; the block SHALL sustain one bit per cycle with no bubble.
REQ-023 mode changes while mid-word SHALL be ignored until the next accepted sof.
REQ-024 The 2's-complement result SHALL wrap modulo 2^WORD_W:
  - 0 maps to 0;
  - 2^(WORD_W-1) maps to itself;
  - neither case is flagged.

Reset
REQ-025 While rst=0, the state SHALL be IDLE, the counter 0, the latched mode 0, and all outputs (out_valid, out_bit, out_sof, out_eow, err_frame) 0, taking effect asynchronously.
REQ-026 Reset asserted mid-word SHALL discard the partial word with no out_eow; the first accepted sof after release SHALL start cleanly.

Structure
REQ-027 Package serial_comp_pkg SHALL hold:
  - the state enumeration (IDLE, ONES, TWOS_PASS, TWOS_INV);
  - the mode constants MODE_ONES=0 and MODE_TWOS=1.
REQ-028 Sub-module serial_comp_ctr SHALL implement the word bit counter (inc, clear, last flag). FSM, datapath and output register SHALL live in serial_complementer.

Verification (WORD_W=8)
REQ-029 Mode 0, word 0x5A, back-to-back bits → 0xA5; out_sof on bit 0, out_eow on bit 7, each output one cycle after its input.
REQ-030 Mode 1, 0x28 → 0xD8; mode 1, 0x00 → 0x00 (the FSM stays in TWOS_PASS); mode 1, 0x80 → 0x80.
REQ-031 Mode 1, 0x01 with in_valid low for 3 cycles after bit 3 → 0xFF; out_valid low exactly 3 cycles; a mode toggle during the stall has no effect.
REQ-032 Mode 0 word 0xF0, then sof at bit 4 starting a mode 1 word 0x03 → err_frame pulses once; no eow for the first word; second word → 0xFD.
REQ-033 Two bits without sof from IDLE → no out_valid, two err_frame pulses.
REQ-034 rst low at bit 5 of a word → all outputs 0 during reset; after release, a mode 0 word 0x00 → 0xFF with correct sof/eow.
